spart_driver: RTL and testbench

//  Bus-side master for the SPART peripheral: drives iocs/iorw/ioaddr/databus.

---
 rtl/spart_driver.sv | 161 ++++++++++++++++
 tb/tb_spart_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/spart_driver.sv
// ---------------------------------------------------------------------------
// spart_driver
//   Bus-side master for the SPART peripheral, standing in for a processor
//   during board bring-up. After reset it programs the 16-bit baud divisor
//   chosen by br_cfg. It then echoes each received byte: read it, wait for
//   the transmitter, and write it back.
//
//   Optional feature macro: SPART_DRV_CASEFLIP_EN
//     defined   : letters A-Z / a-z are echoed with their case swapped
//                 (bit 5 inverted); every other byte passes unchanged
//     undefined : pure echo
//
// Ports
//   clk        in    1  system clock, posedge
//   rst        in    1  synchronous reset, active low
//   br_cfg     in    2  baud select: 00 4800, 01 9600, 10 19200, 11 38400
//   rda        in    1  SPART receive data available
//   tbr        in    1  SPART transmit buffer ready
//   iocs       out   1  chip select, one-cycle strobe per access
//   iorw       out   1  1 = read from SPART, 0 = write to SPART
//   ioaddr     out   2  00 data, 10 divisor low, 11 divisor high
//   databus    inout 8  driven only while iocs=1 and iorw=0
//   echo_byte  out   8  last byte written back to the SPART
//   busy       out   1  low only in IDLE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module spart_driver #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] echo_byte,
  output logic       busy
);

  localparam logic [15:0] DIV_4800 = 16'(CLK_HZ / (16 * 4800));
  localparam logic [15:0] DIV_9600 = 16'(CLK_HZ / (16 * 9600));
  localparam logic [15:0] DIV_19K2 = 16'(CLK_HZ / (16 * 19200));
  localparam logic [15:0] DIV_38K4 = 16'(CLK_HZ / (16 * 38400));

  typedef enum logic [2:0] {
    S_INIT_LO,
    S_INIT_HI,
    S_IDLE,
    S_READ,
    S_WAIT_TBR,
    S_WRITE
  } state_t;

  state_t      r_state;
  logic        r_iocs;
  logic        r_iorw;
  logic [1:0]  r_ioaddr;
  logic [7:0]  r_dout;
  logic [7:0]  r_echo;
  logic [7:0]  r_rx_q;
  logic [1:0]  r_br_cfg_q;
  logic [15:0] w_div;
  logic [7:0]  w_tx;

  // Divisor follows the registered baud select only, so a switch bounce
  // mid-echo cannot change what gets programmed.
  always_comb begin
    w_div = DIV_9600;
    case (r_br_cfg_q)
      2'b00:   w_div = DIV_4800;
      2'b01:   w_div = DIV_9600;
      2'b10:   w_div = DIV_19K2;
      default: w_div = DIV_38K4;
    endcase
  end

`ifdef SPART_DRV_CASEFLIP_EN
  logic w_is_alpha;
  assign w_is_alpha = ((r_rx_q >= 8'h41) && (r_rx_q <= 8'h5A)) ||
                      ((r_rx_q >= 8'h61) && (r_rx_q <= 8'h7A));
  assign w_tx = r_rx_q ^ {2'b00, w_is_alpha, 5'b00000};
`else
  assign w_tx = r_rx_q;
`endif

  // Each state registers its own bus access on the edge that leaves it, so
  // the strobe for a state is visible during the cycle that follows.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_INIT_LO;
      r_iocs     <= 1'b0;
      r_iorw     <= 1'b1;
      r_ioaddr   <= 2'b00;
      r_dout     <= 8'h00;
      r_echo     <= 8'h00;
      r_rx_q     <= 8'h00;
      r_br_cfg_q <= br_cfg;
    end else begin
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_ioaddr <= 2'b00;
      // The read strobe is on the bus this cycle; the SPART is driving it.
      if (r_iocs && r_iorw) r_rx_q <= databus;
      case (r_state)
        S_INIT_LO: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b0;
          r_ioaddr <= 2'b10;
          r_dout   <= w_div[7:0];
          r_state  <= S_INIT_HI;
        end
        S_INIT_HI: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b0;
          r_ioaddr <= 2'b11;
          r_dout   <= w_div[15:8];
          r_state  <= S_IDLE;
        end
        S_IDLE: begin
          // Reprogramming wins over a pending byte; the byte is read after.
          if (br_cfg != r_br_cfg_q) begin
            r_br_cfg_q <= br_cfg;
            r_state    <= S_INIT_LO;
          end else if (rda) begin
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b1;
          r_ioaddr <= 2'b00;
          r_state  <= S_WAIT_TBR;
        end
        S_WAIT_TBR: begin
          if (tbr) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b0;
          r_ioaddr <= 2'b00;
          r_dout   <= w_tx;
          r_echo   <= w_tx;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_INIT_LO;
      endcase
    end
  end

  assign iocs      = r_iocs;
  assign iorw      = r_iorw;
  assign ioaddr    = r_ioaddr;
  assign echo_byte = r_echo;
  assign busy      = (r_state != S_IDLE);
  // Only a write strobe drives; iorw=1 always leaves the bus to the SPART.
  assign databus   = (r_iocs && !r_iorw) ? r_dout : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
`timescale 1ns/1ps
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] echo_byte;
  logic       busy;
  logic [7:0] tb_rx;

  int CHECKS = 0;
  int ERRORS = 0;
  logic [9:0] wq[$];   // {ioaddr, data} of every write strobe seen
  logic [7:0] exp_a;

  spart_driver dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .echo_byte(echo_byte), .busy(busy)
  );

  always #5 clk = ~clk;

  // SPART model: drives the bus during a read strobe.
  assign databus = (iocs && iorw) ? tb_rx : 8'hzz;

  always @(posedge clk)
    if (iocs && !iorw) wq.push_back({ioaddr, databus});

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    CHECKS++;
    assert (obs === exp) else begin
      ERRORS++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wq_at(input int i);
    if (i < wq.size()) return {6'd0, wq[i]};
    return 16'hFFFF;
  endfunction

  initial begin
`ifdef SPART_DRV_CASEFLIP_EN
    exp_a = 8'h61;
`else
    exp_a = 8'h41;
`endif
    rst = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; tb_rx = 8'h00;

    // 1: reset, then divisor 0x028B programmed low then high
    cyc(2);
    chk("rst_iocs", {15'd0, iocs}, 16'd0);
    chk("rst_iorw", {15'd0, iorw}, 16'd1);
    chk("rst_addr", {14'd0, ioaddr}, 16'd0);
    chk("rst_echo", {8'd0, echo_byte}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    cyc();
    chk("init_lo_cs", {14'd0, iocs, iorw}, 16'b10);
    chk("init_lo_ad", {6'd0, ioaddr, databus}, {6'd0, 2'b10, 8'h8B});
    cyc();
    chk("init_hi_ad", {6'd0, ioaddr, databus}, {6'd0, 2'b11, 8'h02});
    chk("init_busy", {15'd0, busy}, 16'd0);
    cyc();
    chk("init_done_cs", {15'd0, iocs}, 16'd0);
    chk("init_nwr", wq.size(), 16'd2);
    chk("init_w0", wq_at(0), {6'd0, 2'b10, 8'h8B});
    chk("init_w1", wq_at(1), {6'd0, 2'b11, 8'h02});
    wq.delete();

    // 2: echo 'A'
    tb_rx = 8'h41; rda = 1'b1; tbr = 1'b1;
    cyc();
    rda = 1'b0;
    chk("e_busy", {15'd0, busy}, 16'd1);
    cyc();
    chk("e_rd", {13'd0, iocs, iorw, 1'b0}, {13'd0, 3'b110});
    chk("e_rd_ad", {14'd0, ioaddr}, 16'd0);
    cyc();
    chk("e_gap", {15'd0, iocs}, 16'd0);
    cyc();
    chk("e_wr", {14'd0, iocs, iorw}, 16'b10);
    chk("e_wr_d", {6'd0, ioaddr, databus}, {8'd0, exp_a});
    chk("e_echo", {8'd0, echo_byte}, {8'd0, exp_a});
    cyc(3);
    chk("e_nwr", wq.size(), 16'd1);
    chk("e_busy_idle", {15'd0, busy}, 16'd0);
    wq.delete();

    // 3: transmitter stalled for 50 cycles
    tb_rx = 8'h7E; rda = 1'b1; tbr = 1'b0;
    cyc();
    rda = 1'b0;
    cyc();
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("stall_cs", {15'd0, iocs}, 16'd0);
    end
    chk("stall_busy", {15'd0, busy}, 16'd1);
    tbr = 1'b1;
    cyc();
    chk("stall_state", {15'd0, iocs}, 16'd0);
    cyc();
    chk("stall_wr", {6'd0, iocs, iorw, databus}, {6'd0, 2'b10, 8'h7E});
    cyc(3);
    chk("stall_nwr", wq.size(), 16'd1);
    wq.delete();

    // move to br_cfg=00 (divisor 0x0516)
    br_cfg = 2'b00;
    cyc(5);
    chk("b00_w0", wq_at(0), {6'd0, 2'b10, 8'h16});
    chk("b00_w1", wq_at(1), {6'd0, 2'b11, 8'h05});
    wq.delete();

    // 4: br_cfg 00->11 while waiting on tbr
    tb_rx = 8'h20; rda = 1'b1; tbr = 1'b0;
    cyc();
    rda = 1'b0;
    cyc(2);
    br_cfg = 2'b11;
    cyc(3);
    chk("defer_nwr", wq.size(), 16'd0);
    tbr = 1'b1;
    cyc(10);
    chk("defer_n", wq.size(), 16'd3);
    chk("defer_w0", wq_at(0), {6'd0, 2'b00, 8'h20});
    chk("defer_w1", wq_at(1), {6'd0, 2'b10, 8'hA2});
    chk("defer_w2", wq_at(2), {6'd0, 2'b11, 8'h00});
    chk("defer_echo", {8'd0, echo_byte}, 16'h0020);
    wq.delete();

    // 5: reset during the read strobe
    tb_rx = 8'h55; rda = 1'b1; tbr = 1'b1;
    cyc();
    rda = 1'b0;
    cyc();
    chk("mr_rd", {14'd0, iocs, iorw}, 16'b11);
    rst = 1'b0;
    cyc();
    chk("mr_cs", {14'd0, iocs, iorw}, 16'b01);
    chk("mr_echo", {8'd0, echo_byte}, 16'd0);
    chk("mr_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1; tbr = 1'b0;
    cyc();
    chk("mr_lo", {6'd0, ioaddr, databus}, {6'd0, 2'b10, 8'hA2});
    cyc(4);
    chk("mr_n", wq.size(), 16'd2);
    chk("mr_w1", wq_at(1), {6'd0, 2'b11, 8'h00});
    wq.delete();

    // reprogram and pending byte together: reprogram first, then echo
    br_cfg = 2'b10; rda = 1'b1; tbr = 1'b1; tb_rx = 8'h30;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (iocs && iorw) rda = 1'b0;
    end
    chk("both_n", wq.size(), 16'd3);
    chk("both_w0", wq_at(0), {6'd0, 2'b10, 8'h45});
    chk("both_w1", wq_at(1), {6'd0, 2'b11, 8'h01});
    chk("both_w2", wq_at(2), {6'd0, 2'b00, 8'h30});
    wq.delete();

    // 6: digit passes unchanged
    tb_rx = 8'h35; rda = 1'b1; tbr = 1'b1;
    cyc();
    rda = 1'b0;
    cyc(3);
    chk("dig_wr", {6'd0, iocs, iorw, databus}, {6'd0, 2'b10, 8'h35});
    chk("dig_echo", {8'd0, echo_byte}, 16'h0035);

    $display("CHECKS %0d ERRORS %0d", CHECKS, ERRORS);
    $finish;
  end

endmodule
